wb_buffer: RTL and testbench
============================

WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffer entries (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_W, default 8, RAM address width (cache tag width).
REQ-003 SHALL have parameter DATA_W, default 8, data width.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wb_valid  input  1  cache presents an evicted dirty block.
REQ-007 SHALL have port wb_addr  input  ADDR_W  RAM address of the evicted block.
REQ-008 SHALL have port wb_data  input  DATA_W  data of the evicted block.
REQ-009 SHALL have port wb_ready  output  1  buffer can accept the block this cycle.
REQ-010 SHALL have port mem_req  output  1  write request to RAM.
REQ-011 SHALL have port mem_addr  output  ADDR_W  RAM write address.
REQ-012 SHALL have port mem_wdata  output  DATA_W  RAM write data.
REQ-013 SHALL have port mem_ack  input  1  RAM accepted the current write.
REQ-014 SHALL have port rd_addr  input  ADDR_W  address of a cache miss fill being looked up.
REQ-015 SHALL have port rd_hit  output  1  rd_addr matches a buffered entry.
REQ-016 SHALL have port rd_data  output  DATA_W  forwarded data on rd_hit, else 0.
REQ-017 SHALL have ports full, empty  output  1 each, and count  output  log2(DEPTH)+1  occupancy.

Function
REQ-018 SHALL be a FIFO: push when wb_valid && wb_ready; entry stored at tail, tail and count advance next edge.
REQ-019 SHALL drive wb_ready = !full combinationally; push while full SHALL NOT occur, even if a pop happens the same cycle.
REQ-020 SHALL implement drain FSM with states IDLE and WRITE; IDLE -> WRITE on the edge where count becomes nonzero.
REQ-021 SHALL in WRITE hold mem_req=1 with mem_addr/mem_wdata equal to the head entry, stable until mem_ack.
REQ-022 SHALL on mem_ack in WRITE pop the head; remain WRITE if entries remain after the pop (including a same-cycle push), else return to IDLE.
REQ-023 SHALL ignore mem_ack in IDLE; mem_req SHALL be 0 in IDLE.
REQ-024 SHALL on simultaneous push and pop keep count unchanged and advance both pointers.
REQ-025 SHALL wrap head/tail pointers modulo DEPTH.
REQ-026 SHALL compute rd_hit/rd_data combinationally over all valid entries; on multiple matches the youngest entry wins.
REQ-027 SHALL assert full when count==DEPTH, empty when count==0.

Reset
REQ-028 SHALL on reset immediately clear head, tail, count, valid bits; FSM to IDLE; mem_req=0, rd_hit=0, rd_data=0, wb_ready=1, empty=1, full=0.
REQ-029 SHALL discard buffered and in-flight writes on reset mid-operation; a mem_ack arriving after reset is ignored.

Configuration
REQ-030 SHALL honour macro WB_BUFFER_COALESCE_EN.
REQ-031 SHALL, with WB_BUFFER_COALESCE_EN defined, on push whose wb_addr matches a valid entry other than the head in WRITE, overwrite that entry's data without allocating; such a push SHALL be accepted even when full (wb_ready = !full || match).
REQ-032 SHALL, without WB_BUFFER_COALESCE_EN, always allocate a new entry per push; duplicate addresses drain in order.

Verification
REQ-033 Reset, push (0x12,0xAA), mem_ack held 0 -> mem_req=1 from 2nd edge, mem_addr=0x12, mem_wdata=0xAA, stable; ack -> empty=1, IDLE.
REQ-034 Push 4 entries 0x01..0x04 with mem_ack=0 -> full=1, wb_ready=0, 5th push rejected; 4 acks -> writes in order 0x01..0x04.
REQ-035 Buffer holds (0x30,0x11) then (0x30,0x22) (no coalesce) -> rd_addr=0x30 gives rd_hit=1, rd_data=0x22; rd_addr=0x31 gives rd_hit=0, rd_data=0.
REQ-036 count=2, push and mem_ack same cycle -> count stays 2, FSM stays WRITE, tail wraps past DEPTH-1 correctly.
REQ-037 With WB_BUFFER_COALESCE_EN: entries (0x05,0x10 head in flight),(0x07,0x20); push (0x07,0x99) -> count=2, later write 0x07<-0x99; push (0x05,0x77) -> new entry.
REQ-038 Reset asserted while mem_req=1 with 3 entries -> mem_req=0 and empty=1 immediately, no further writes after mem_ack.

Source files
------------

// File: rtl/wb_buffer.sv
// rtl/wb_buffer.sv - write-back buffer: FIFO of evicted blocks drained to RAM, with read forwarding.
// Optional WB_BUFFER_COALESCE_EN merges a push into a queued (not in-flight) entry with the same address.
module wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wb_ready,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_hit,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DEPTH-1:0]    valid_q;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];

  logic                push, pop, alloc, coal;
  logic                co_hit;
  logic [PTR_W-1:0]    co_idx;
  logic [PTR_W-1:0]    rd_idx;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign wb_ready = !full || co_hit;

  assign push  = wb_valid && wb_ready;
  assign pop   = (state_q == WRITE) && mem_ack;
  assign alloc = push && !co_hit;
  assign coal  = push && co_hit;

`ifdef WB_BUFFER_COALESCE_EN
  // The head is excluded while in flight so mem_wdata stays stable until mem_ack.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == wb_addr) &&
          !((state_q == WRITE) && (PTR_W'(i) == head_q))) begin
        co_hit = 1'b1;
        co_idx = PTR_W'(i);
      end
    end
  end
`else
  assign co_hit = 1'b0;
  assign co_idx = '0;
`endif

  always_comb begin
    count_d = count_q;
    if (alloc && !pop)
      count_d = count_q + 1'b1;
    else if (!alloc && pop)
      count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (count_d != '0)
          state_d = WRITE;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = data_q[head_q];
        if (mem_ack && (count_d == '0))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pop) begin
        head_q          <= head_q + 1'b1;
        valid_q[head_q] <= 1'b0;
      end
      if (alloc) begin
        tail_q          <= tail_q + 1'b1;
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify every entry.
  always_ff @(posedge clock) begin
    if (alloc) begin
      addr_q[tail_q] <= wb_addr;
      data_q[tail_q] <= wb_data;
    end
    if (coal)
      data_q[co_idx] <= wb_data;
  end

  // Scan oldest to youngest so the youngest match is left standing.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    rd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = head_q + PTR_W'(i);
      if (valid_q[rd_idx] && (addr_q[rd_idx] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = data_q[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_buffer.sv
// tb/tb_wb_buffer.sv - directed self-checking bench for wb_buffer.
module tb_wb_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic       wb_valid;
  logic [7:0] wb_addr;
  logic [7:0] wb_data;
  logic       wb_ready;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] rd_addr;
  logic       rd_hit;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  wb_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
    .full(full), .empty(empty), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic ack_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(a));
    check({tag, "_data"}, 32'(mem_wdata), 32'(d));
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; mem_ack = 1'b0; rd_addr = '0;
    step();
    step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rd_hit", 32'(rd_hit), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_wb_ready", 32'(wb_ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    step();

    // single write held until ack
    push(8'h12, 8'hAA);
    check("s_count", 32'(count), 32'd1);
    step();
    step();
    ack_write("s_held", 8'h12, 8'hAA);
    check("s_empty", 32'(empty), 32'd1);
    check("s_idle_req", 32'(mem_req), 32'd0);

    // fill to full, reject fifth, drain in order
    for (int i = 1; i <= 4; i++) push(8'(i), 8'(8'h10 + i));
    check("f_full", 32'(full), 32'd1);
    check("f_ready", 32'(wb_ready), 32'd0);
    check("f_count", 32'(count), 32'd4);
    push(8'h05, 8'h55);
    check("f_reject_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) ack_write("f_drain", 8'(i), 8'(8'h10 + i));
    check("f_empty", 32'(empty), 32'd1);

    // ack in IDLE must be ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("idle_ack_count", 32'(count), 32'd0);
    check("idle_ack_req", 32'(mem_req), 32'd0);

    // forwarding, youngest duplicate wins
    push(8'h30, 8'h11);
    push(8'h30, 8'h22);
    rd_addr = 8'h30;
    #1;
    check("fw_hit", 32'(rd_hit), 32'd1);
    check("fw_data", 32'(rd_data), 32'h22);
    rd_addr = 8'h31;
    #1;
    check("fw_miss_hit", 32'(rd_hit), 32'd0);
    check("fw_miss_data", 32'(rd_data), 32'd0);
    ack_write("fw_d0", 8'h30, 8'h11);
    ack_write("fw_d1", 8'h30, 8'h22);

    // simultaneous push and pop with tail wrapping
    push(8'h40, 8'hA0);
    push(8'h41, 8'hA1);
    check("pp_count_pre", 32'(count), 32'd2);
    wb_valid = 1'b1; wb_addr = 8'h42; wb_data = 8'hA2; mem_ack = 1'b1;
    step();
    wb_valid = 1'b0; mem_ack = 1'b0;
    check("pp_count", 32'(count), 32'd2);
    check("pp_req", 32'(mem_req), 32'd1);
    ack_write("pp_d0", 8'h41, 8'hA1);
    ack_write("pp_d1", 8'h42, 8'hA2);
    check("pp_empty", 32'(empty), 32'd1);

`ifdef WB_BUFFER_COALESCE_EN
    push(8'h05, 8'h10);
    push(8'h07, 8'h20);
    push(8'h07, 8'h99);
    check("co_merge_count", 32'(count), 32'd2);
    push(8'h05, 8'h77);
    check("co_head_count", 32'(count), 32'd3);
    ack_write("co_d0", 8'h05, 8'h10);
    ack_write("co_d1", 8'h07, 8'h99);
    ack_write("co_d2", 8'h05, 8'h77);
`else
    push(8'h05, 8'h10);
    push(8'h07, 8'h20);
    push(8'h07, 8'h99);
    check("nc_count", 32'(count), 32'd3);
    ack_write("nc_d0", 8'h05, 8'h10);
    ack_write("nc_d1", 8'h07, 8'h20);
    ack_write("nc_d2", 8'h07, 8'h99);
`endif
    check("cfg_empty", 32'(empty), 32'd1);

    // reset mid-operation
    push(8'h50, 8'hB0);
    push(8'h51, 8'hB1);
    push(8'h52, 8'hB2);
    check("mr_count", 32'(count), 32'd3);
    check("mr_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    rd_addr = 8'h50;
    #1;
    check("mr_async_req", 32'(mem_req), 32'd0);
    check("mr_async_empty", 32'(empty), 32'd1);
    check("mr_async_hit", 32'(rd_hit), 32'd0);
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    check("mr_post_req", 32'(mem_req), 32'd0);
    check("mr_post_count", 32'(count), 32'd0);
    check("mr_post_ready", 32'(wb_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
